// File: rtl/seq_pkg.sv
// ============================================================================
// Module  : seq_pkg
// Purpose : Shared state/sub-step enums and instruction bit positions.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_QWR   = 4'd1,
    S_KWR   = 4'd2,
    S_KLOAD = 4'd3,
    S_WAIT1 = 4'd4,
    S_EXEC  = 4'd5,
    S_WAIT2 = 4'd6,
    S_OFIFO = 4'd7,
    S_SFP   = 4'd8,
    S_DONE  = 4'd9
  } state_t;

  typedef enum logic [2:0] {
    SFP_RD   = 3'd0,
    SFP_ACC  = 3'd1,
    SFP_DIV1 = 3'd2,
    SFP_DIV2 = 3'd3,
    SFP_WB   = 3'd4,
    SFP_NEXT = 3'd5
  } sfp_step_t;

  localparam int INST_W       = 19;
  localparam int B_SFP_DIV    = 18;
  localparam int B_SFP_ACC    = 17;
  localparam int B_OFIFO_RD   = 16;
  localparam int B_QKMEM_LSB  = 12;
  localparam int B_PMEM_LSB   = 8;
  localparam int B_EXECUTE    = 7;
  localparam int B_LOAD       = 6;
  localparam int B_QMEM_RD    = 5;
  localparam int B_QMEM_WR    = 4;
  localparam int B_KMEM_RD    = 3;
  localparam int B_KMEM_WR    = 2;
  localparam int B_PMEM_RD    = 1;
  localparam int B_PMEM_WR    = 0;

endpackage

`default_nettype wire

// File: rtl/seq_addr_cnt.sv
// ============================================================================
// Module  : seq_addr_cnt
// Purpose : Loadable / clearable address counter (clear > load > increment).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module seq_addr_cnt #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_load_val,
  input  logic              i_inc,
  output logic [ADDR_W-1:0] o_cnt
);

  logic [ADDR_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_cnt <= '0;
    else if (i_clr)  r_cnt <= '0;
    else if (i_load) r_cnt <= i_load_val;
    else if (i_inc)  r_cnt <= r_cnt + 1'b1;
  end

  assign o_cnt = r_cnt;

endmodule

`default_nettype wire

// File: rtl/inst_sequencer.sv
// ============================================================================
// Module  : inst_sequencer
// Purpose : Drives the fullchip instruction word through a full attention run.
//           Optional SFP normalisation phase: define INST_SEQUENCER_SFP_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module inst_sequencer
  import seq_pkg::*;
#(
  parameter int TOTAL_CYCLE = 8,
  parameter int COL         = 8,
  parameter int WAIT_CYC    = 10,
  parameter int ADDR_W      = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [INST_W-1:0] inst,
  output logic              busy,
  output logic              done
);

  localparam logic [15:0] c_TC_M1   = 16'(TOTAL_CYCLE - 1);
  localparam logic [15:0] c_COL     = 16'(COL);
  localparam logic [15:0] c_COL_M1  = 16'(COL - 1);
  localparam logic [15:0] c_COL_P1  = 16'(COL + 1);
  localparam logic [15:0] c_COL_P2  = 16'(COL + 2);
  localparam logic [15:0] c_WAIT_M1 = 16'(WAIT_CYC - 1);

  state_t              r_state;
  logic [INST_W-1:0]   r_ctl;
  logic [15:0]         r_cnt;
  logic                r_in_ready, r_busy, r_done;
  logic                r_qk_adv, r_qk_end, r_p_adv, r_p_end;
  logic [15:0]         w_n;
  logic [ADDR_W-1:0]   w_qk_add, w_p_add;
`ifdef INST_SEQUENCER_SFP_EN
  localparam logic [ADDR_W-1:0] c_TC_LAST_A = ADDR_W'(TOTAL_CYCLE - 1);
  sfp_step_t           r_sub;
`endif

  assign w_n = r_cnt + 16'd1;

  // Address lags its strobe by design: r_*_adv marks a displayed access, so the
  // counter steps (or clears after the last one) on the edge that ends it.
  seq_addr_cnt #(.ADDR_W(ADDR_W)) u_qk_cnt (
    .clk(clk), .rst(reset),
    .i_clr(r_qk_adv & r_qk_end), .i_load(1'b0), .i_load_val('0),
    .i_inc(r_qk_adv & ~r_qk_end), .o_cnt(w_qk_add)
  );

  seq_addr_cnt #(.ADDR_W(ADDR_W)) u_p_cnt (
    .clk(clk), .rst(reset),
    .i_clr(r_p_adv & r_p_end), .i_load(1'b0), .i_load_val('0),
    .i_inc(r_p_adv & ~r_p_end), .o_cnt(w_p_add)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_ctl      <= '0;
      r_cnt      <= '0;
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_qk_adv   <= 1'b0;
      r_qk_end   <= 1'b0;
      r_p_adv    <= 1'b0;
      r_p_end    <= 1'b0;
`ifdef INST_SEQUENCER_SFP_EN
      r_sub      <= SFP_RD;
`endif
    end else begin
      r_ctl    <= '0;
      r_qk_adv <= 1'b0;
      r_qk_end <= 1'b0;
      r_p_adv  <= 1'b0;
      r_p_end  <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          r_state    <= S_QWR;
          r_in_ready <= 1'b1;
          r_busy     <= 1'b1;
          r_cnt      <= '0;
        end
        S_QWR: if (in_valid && r_in_ready) begin
          r_ctl[B_QMEM_WR] <= 1'b1;
          r_qk_adv         <= 1'b1;
          r_cnt            <= w_n;
          if (r_cnt == c_TC_M1) begin
            r_qk_end <= 1'b1;
            r_state  <= S_KWR;
            r_cnt    <= '0;
          end
        end
        S_KWR: if (in_valid && r_in_ready) begin
          r_ctl[B_KMEM_WR] <= 1'b1;
          r_qk_adv         <= 1'b1;
          r_cnt            <= w_n;
          if (r_cnt == c_COL_M1) begin
            // The last K write is still on inst next cycle, so KLOAD counting
            // starts one cycle later (index wraps to 0 on the following edge).
            r_qk_end   <= 1'b1;
            r_in_ready <= 1'b0;
            r_state    <= S_KLOAD;
            r_cnt      <= '1;
          end
        end
        S_KLOAD: begin
          r_cnt <= w_n;
          if (r_cnt == c_COL_P2) begin
            r_state <= S_WAIT1;
            r_cnt   <= '0;
          end else begin
            r_ctl[B_LOAD] <= (w_n <= c_COL_P1);
            if (w_n >= 16'd1 && w_n <= c_COL) begin
              r_ctl[B_KMEM_RD] <= 1'b1;
              r_qk_adv         <= 1'b1;
              r_qk_end         <= (w_n == c_COL);
            end
          end
        end
        S_WAIT1: begin
          r_cnt <= w_n;
          if (r_cnt == c_WAIT_M1) begin
            r_state          <= S_EXEC;
            r_cnt            <= '0;
            r_ctl[B_EXECUTE] <= 1'b1;
            r_ctl[B_QMEM_RD] <= 1'b1;
            r_qk_adv         <= 1'b1;
            r_qk_end         <= (c_TC_M1 == 16'd0);
          end
        end
        S_EXEC: begin
          r_cnt <= w_n;
          if (r_cnt == c_TC_M1) begin
            r_state <= S_WAIT2;
            r_cnt   <= '0;
          end else begin
            r_ctl[B_EXECUTE] <= 1'b1;
            r_ctl[B_QMEM_RD] <= 1'b1;
            r_qk_adv         <= 1'b1;
            r_qk_end         <= (w_n == c_TC_M1);
          end
        end
        S_WAIT2: begin
          r_cnt <= w_n;
          if (r_cnt == c_WAIT_M1) begin
            r_state           <= S_OFIFO;
            r_cnt             <= '0;
            r_ctl[B_OFIFO_RD] <= 1'b1;
            r_ctl[B_PMEM_WR]  <= 1'b1;
            r_p_adv           <= 1'b1;
            r_p_end           <= (c_TC_M1 == 16'd0);
          end
        end
        S_OFIFO: begin
          r_cnt <= w_n;
          if (r_cnt == c_TC_M1) begin
            r_cnt <= '0;
`ifdef INST_SEQUENCER_SFP_EN
            r_state          <= S_SFP;
            r_sub            <= SFP_RD;
            r_ctl[B_PMEM_RD] <= 1'b1;
`else
            r_state <= S_DONE;
            r_done  <= 1'b1;
`endif
          end else begin
            r_ctl[B_OFIFO_RD] <= 1'b1;
            r_ctl[B_PMEM_WR]  <= 1'b1;
            r_p_adv           <= 1'b1;
            r_p_end           <= (w_n == c_TC_M1);
          end
        end
`ifdef INST_SEQUENCER_SFP_EN
        S_SFP: begin
          case (r_sub)
            SFP_RD: begin
              r_sub            <= SFP_ACC;
              r_ctl[B_PMEM_RD] <= 1'b1;
              r_ctl[B_SFP_ACC] <= 1'b1;
            end
            SFP_ACC, SFP_DIV1: begin
              r_sub            <= (r_sub == SFP_ACC) ? SFP_DIV1 : SFP_DIV2;
              r_ctl[B_PMEM_RD] <= 1'b1;
              r_ctl[B_SFP_DIV] <= 1'b1;
            end
            SFP_DIV2: begin
              r_sub            <= SFP_WB;
              r_ctl[B_PMEM_WR] <= 1'b1;
              r_ctl[B_SFP_DIV] <= 1'b1;
            end
            SFP_WB: begin
              r_sub   <= SFP_NEXT;
              r_p_adv <= 1'b1;
              r_p_end <= (w_p_add == c_TC_LAST_A);
            end
            default: begin
              if (r_p_end) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end else begin
                r_sub            <= SFP_RD;
                r_ctl[B_PMEM_RD] <= 1'b1;
              end
            end
          endcase
        end
`endif
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state    <= S_IDLE;
          r_busy     <= 1'b0;
          r_in_ready <= 1'b0;
        end
      endcase
    end
  end

  assign inst = r_ctl
              | (INST_W'(w_qk_add) << B_QKMEM_LSB)
              | (INST_W'(w_p_add)  << B_PMEM_LSB);
  assign in_ready = r_in_ready;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

`default_nettype wire

// File: doc/inst_sequencer.md
INST_SEQUENCER -- requirements
Module: inst_sequencer

Interface
REQ-001 SHALL have parameter TOTAL_CYCLE, default 8, meaning the number of Q rows processed.
REQ-002 SHALL have parameter COL, default 8, meaning the number of K rows to load.
REQ-003 SHALL have parameter WAIT_CYC, default 10, meaning the idle cycles after K load and after execute.
REQ-004 SHALL have parameter ADDR_W, default 4, meaning the qkmem/pmem address width.
REQ-005 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 Port start, input, 1 bit: pulse that begins a full run.
REQ-008 Port in_valid, input, 1 bit: host has a Q or K row on mem_in.
REQ-009 Port in_ready, output, 1 bit: the sequencer accepts a host row this cycle.
REQ-010 Port inst, output, 19 bits: fullchip instruction word, with fields [18] sfp_div, [17] sfp_acc, [16] ofifo_rd, [15:12] qkmem_add, [11:8] pmem_add, [7] execute, [6] load, [5] qmem_rd, [4] qmem_wr, [3] kmem_rd, [2] kmem_wr, [1] pmem_rd, [0] pmem_wr.
REQ-011 Port busy, output, 1 bit: high in every state except IDLE.
REQ-012 Port done, output, 1 bit: one-cycle pulse at run end.

Function
REQ-013 SHALL have states IDLE, QWR, KWR, KLOAD, WAIT1, EXEC, WAIT2, OFIFO, SFP, DONE, with transitions taken in that order.
REQ-014 All outputs SHALL be registered; inst SHALL change only on the rising clk edge.
REQ-015 In IDLE, start SHALL move the block to QWR; start SHALL be ignored in all other states.
REQ-016 In QWR, in_ready SHALL be 1; qmem_wr SHALL equal in_valid; each accepted beat (in_valid & in_ready) SHALL increment qkmem_add from 0.
REQ-017 After TOTAL_CYCLE accepted beats, QWR SHALL clear qkmem_add to 0 and move to KWR.
REQ-018 KWR SHALL behave identically to QWR using kmem_wr, for COL beats.
REQ-019 A missing in_valid SHALL stall the write phase with no write and no address change.
REQ-020 KLOAD SHALL last COL+3 cycles with load=1 for the first COL+2 cycles.
REQ-021 In KLOAD, kmem_rd SHALL be 1 in cycles 1..COL; qkmem_add SHALL increment from cycle 2.
REQ-022 In the last KLOAD cycle, kmem_rd=0 and qkmem_add=0.
REQ-023 WAIT1 and WAIT2 SHALL each hold inst=0 for WAIT_CYC cycles.
REQ-024 EXEC SHALL assert execute=1 and qmem_rd=1 for TOTAL_CYCLE cycles with qkmem_add 0..TOTAL_CYCLE-1, then deassert both and set qkmem_add=0.
REQ-025 OFIFO SHALL assert ofifo_rd=1 and pmem_wr=1 for TOTAL_CYCLE cycles with pmem_add 0..TOTAL_CYCLE-1.
REQ-026 SFP SHALL run 6 cycles per row at constant pmem_add: RD{pmem_rd}, ACC{pmem_rd, sfp_acc}, DIV1{pmem_rd, sfp_div}, DIV2{pmem_rd, sfp_div}, WB{pmem_wr, sfp_div}, NEXT{none}.
REQ-027 NEXT SHALL increment pmem_add; after row TOTAL_CYCLE-1, SFP SHALL move to DONE with pmem_add=0.
REQ-028 pmem_rd and pmem_wr SHALL never both be 1 in the same cycle.
REQ-029 Address counters SHALL never wrap within a phase; TOTAL_CYCLE and COL SHALL be at most 2^ADDR_W.
REQ-030 DONE SHALL last 1 cycle, pulse done=1, drive inst=0, and return to IDLE.

Reset
REQ-031 Reset SHALL asynchronously force state IDLE, inst=0, all counters=0, in_ready=0, busy=0 and done=0.
REQ-032 Reset asserted mid-run SHALL abandon the run; no further inst bits SHALL assert until the next start.

Configuration
REQ-033 With macro INST_SEQUENCER_SFP_EN defined, the SFP state SHALL be compiled in and entered after OFIFO.
REQ-034 Without INST_SEQUENCER_SFP_EN, OFIFO SHALL go directly to DONE, and inst[18:17] SHALL be constant 0.

Structure
REQ-035 Shared package seq_pkg SHALL hold the state enum, the inst bit-position constants and the SFP sub-step enum.
REQ-036 One sub-module, seq_addr_cnt, SHALL provide the loadable/clearable ADDR_W counter, instanced for qkmem_add and for pmem_add.

Verification
REQ-037 Default parameters, start, in_valid held 1 -> QWR writes addresses 0..7 in 8 cycles, then KWR writes addresses 0..7 in 8 cycles, with 0 stalls.
REQ-038 in_valid low on the 3rd Q beat for 2 cycles -> qmem_wr=0 and qkmem_add held at 2 for 2 cycles; total of 8 writes.
REQ-039 KLOAD checks -> load high for 10 cycles, kmem_rd high for 8 cycles, qkmem_add sequence 0,0,1..7,0.
REQ-040 Full run with INST_SEQUENCER_SFP_EN -> per row, inst[18:17],[1:0] follow RD..NEXT; 48 SFP cycles; done pulses once.
REQ-041 Full run without the macro -> done one cycle after the last OFIFO beat; sfp_acc and sfp_div never asserted.
REQ-042 Reset at EXEC cycle 4 -> inst=0 immediately; start reissued -> run restarts at QWR with address 0.
